// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, four
// registered digits, overflow saturation above 9999.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// CONV   | one add-3/shift step per cycle, WIDTH cycles total
// DONE   | load digit outputs and overflow, pulse done
module bcd_seq_ctrl #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [15:0]      acc_q, acc_d, acc_adj;
    logic [CW-1:0]    cnt_q;
    logic             ovf_cap_q, ovf_in;
    logic             busy_q, done_q, ovf_q;
    logic [3:0]       d3_q, d2_q, d1_q, d0_q;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        {acc_d, sh_d} = {acc_adj, sh_q} << 1;
        ovf_in = ({{(32-WIDTH){1'b0}}, bin} > 32'd9999);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            d3_q      <= '0;
            d2_q      <= '0;
            d1_q      <= '0;
            d0_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        sh_q      <= bin;
                        acc_q     <= '0;
                        cnt_q     <= CW'(WIDTH);
                        ovf_cap_q <= ovf_in;
                        busy_q    <= 1'b1;
                        state_q   <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // busy stays high through the done cycle and drops in IDLE
                    done_q  <= 1'b1;
                    ovf_q   <= ovf_cap_q;
                    state_q <= S_IDLE;
                    if (ovf_cap_q) begin
                        d3_q <= 4'd9;
                        d2_q <= 4'd9;
                        d1_q <= 4'd9;
                        d0_q <= 4'd9;
                    end else begin
                        d3_q <= acc_q[15:12];
                        d2_q <= acc_q[11:8];
                        d1_q <= acc_q[7:4];
                        d0_q <= acc_q[3:0];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign thousands = d3_q;
    assign hundreds  = d2_q;
    assign tens      = d1_q;
    assign ones      = d0_q;
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: driver predicts accepted conversions and
// their results arithmetically; monitor checks busy, done timing and digits.
module tb_bcd_seq_ctrl;
    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] bin = '0;
    logic         busy, done, overflow;
    logic [3:0]   thousands, hundreds, tens, ones;

    bcd_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .overflow(overflow),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          free_edge = 0;
    int          n_conv = 0;
    bit          armed = 1'b0;
    logic [16:0] exp_q[$];
    int          edge_q[$];
    logic [16:0] last_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // {overflow, thousands, hundreds, tens, ones} from plain decimal arithmetic
    function automatic logic [16:0] model(input int v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // called at a negedge; applies inputs for the next rising edge
    task automatic step(input logic s, input int b, input logic r);
        int e;
        start = s;
        bin   = W'(b);
        rst   = r;
        e = cyc + 1;
        if (r) begin
            exp_q.delete();
            edge_q.delete();
            free_edge = e + 1;
            last_val  = '0;
        end else if (s && e >= free_edge) begin
            exp_q.push_back(model(b));
            edge_q.push_back(e);
            free_edge = e + W + 2;
            n_conv++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (edge_q.size() > 0 && n < 100) begin
            step(1'b0, 0, 1'b0);
            n++;
        end
        chk("drain_timeout", 32'(edge_q.size()), 32'd0);
        step(1'b0, 0, 1'b0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_out"}, 32'({overflow, thousands, hundreds, tens, ones}), 32'd0);
    endtask

    // monitor
    always begin
        logic        busy_exp;
        logic [16:0] act;
        @(posedge clk);
        cyc++;
        #1;
        if (armed) begin
            act = {overflow, thousands, hundreds, tens, ones};
            busy_exp = (edge_q.size() > 0) && (cyc >= edge_q[0]) && (cyc <= edge_q[0] + W + 1);
            chk("busy", 32'(busy), 32'(busy_exp));
            if (done) begin
                if (edge_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    chk("done_edge", 32'(cyc), 32'(edge_q[0] + W + 1));
                    chk("result", 32'(act), 32'(exp_q[0]));
                    last_val = exp_q[0];
                    void'(exp_q.pop_front());
                    void'(edge_q.pop_front());
                end
            end else begin
                if (edge_q.size() > 0 && cyc > edge_q[0] + W + 1) begin
                    chk("missing_done", 32'(done), 32'd1);
                    void'(exp_q.pop_front());
                    void'(edge_q.pop_front());
                end
                chk("hold", 32'(act), 32'(last_val));
            end
        end
    end

    initial begin
        @(negedge clk);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk_zero("reset");
        armed = 1'b1;

        // reset wins over a simultaneous start
        step(1'b1, 1234, 1'b1);
        chk_zero("rst_prio");
        step(1'b0, 0, 1'b0);

        step(1'b1, 1234, 1'b0);
        drain();
        chk("r1234", 32'({thousands, hundreds, tens, ones}), 32'h1234);

        step(1'b1, 9999, 1'b0);  drain();
        step(1'b1, 10000, 1'b0); drain();
        chk("ovf10000", 32'(overflow), 32'd1);
        step(1'b1, 16383, 1'b0); drain();
        step(1'b1, 0, 1'b0);     drain();
        step(1'b1, 5, 1'b0);     drain();

        // start held continuously, operand changes mid-conversion
        repeat (5) step(1'b1, 42, 1'b0);
        repeat (W + 2) step(1'b1, 77, 1'b0);
        step(1'b0, 0, 1'b0);
        drain();
        chk("held_last", 32'({thousands, hundreds, tens, ones}), 32'h0077);

        // reset in the middle of a conversion
        step(1'b1, 4321, 1'b0);
        repeat (4) step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        chk_zero("abort");
        step(1'b1, 4321, 1'b0);
        drain();
        chk("r4321", 32'({thousands, hundreds, tens, ones}), 32'h4321);

        // random sweep with starts issued while busy
        for (int i = 0; i < 40000 && n_conv < 1120; i++) begin
            int v;
            case ($urandom_range(0, 7))
                0:       v = 9999 + $urandom_range(0, 1);
                1:       v = $urandom_range(0, 15);
                default: v = $urandom_range(0, 16383);
            endcase
            step($urandom_range(0, 3) != 0, v, 1'b0);
        end
        drain();
        chk("sweep_count", 32'(n_conv >= 1000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
